// File: rtl/sprite_palette_pkg.sv
// Shared types and the power-on colour set for the sprite palette bank.
package sprite_palette_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    FLASH_ON  = 2'd1,
    FLASH_OFF = 2'd2
  } flash_state_t;

  // Native format of the default palette: 4 bits per channel.
  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb_t;

  localparam int DEF_DEPTH = 16;

  // Standard snake colour set, {r,g,b} per entry.
  localparam logic [11:0] DEFAULT_PALETTE [DEF_DEPTH] = '{
    12'h2C7, 12'hF0F, 12'hB5E, 12'h975, 12'hB99, 12'hF69, 12'hE33, 12'h1E6,
    12'hDCC, 12'h9DB, 12'h3D7, 12'h2B6, 12'h5D9, 12'h7A8, 12'h1C6, 12'hE9A
  };

  // Entries beyond the default set come up black.
  function automatic rgb_t default_entry(input int i);
    if (i < DEF_DEPTH) return rgb_t'(DEFAULT_PALETTE[i[3:0]]);
    return '0;
  endfunction

endpackage

// File: rtl/palette_flash_ctrl.sv
// Frame-synchronous flash sequencer: alternates invert on/off every
// FLASH_FRAMES vsync pulses while flash_en is held.
module palette_flash_ctrl
  import sprite_palette_pkg::*;
#(
  parameter int FLASH_FRAMES = 8
) (
  input  logic Clk,
  input  logic Reset,
  input  logic flash_en,
  input  logic vsync_pulse,
  output logic invert_active
);

  localparam int CW = $clog2(FLASH_FRAMES) + 1;
  localparam logic [CW-1:0] LAST = CW'(FLASH_FRAMES - 1);

  flash_state_t state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;

  // State and frame counter registers.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next state: dropping flash_en wins over a same-cycle vsync.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (!flash_en) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end else begin
      case (state)
        IDLE: begin
          state_nxt = FLASH_ON;
          cnt_nxt   = '0;
        end
        FLASH_ON, FLASH_OFF: begin
          if (vsync_pulse) begin
            if (cnt == LAST) begin
              cnt_nxt   = '0;
              state_nxt = (state == FLASH_ON) ? FLASH_OFF : FLASH_ON;
            end else begin
              cnt_nxt = cnt + 1'b1;
            end
          end
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  assign invert_active = (state == FLASH_ON);

endmodule

// File: rtl/sprite_palette_bank.sv
// Runtime-writable multi-palette colour lookup with transparency key
// and flash (colour invert); one cycle from index to registered RGB.
module sprite_palette_bank
  import sprite_palette_pkg::*;
#(
  parameter int IDX_W        = 4,
  parameter int COLOR_W      = 4,
  parameter int NUM_PAL      = 2,
  parameter int TRANSP_IDX   = 1,
  parameter int FLASH_FRAMES = 8,
  localparam int PS_W  = (NUM_PAL > 1) ? $clog2(NUM_PAL) : 1,
  localparam int DEPTH = 2 ** IDX_W,
  localparam int RGB_W = 3 * COLOR_W
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               pix_valid,
  input  logic [PS_W-1:0]    pal_sel,
  input  logic [IDX_W-1:0]   index,
  input  logic               vsync_pulse,
  input  logic               flash_en,
  input  logic               wr_en,
  input  logic [PS_W-1:0]    wr_pal,
  input  logic [IDX_W-1:0]   wr_idx,
  input  logic [RGB_W-1:0]   wr_rgb,
  output logic [COLOR_W-1:0] red,
  output logic [COLOR_W-1:0] green,
  output logic [COLOR_W-1:0] blue,
  output logic               transparent,
  output logic               out_valid
);

  // Left-justify a 4-bit default channel into COLOR_W bits.
  function automatic logic [COLOR_W-1:0] scale_chan(input logic [3:0] c);
    logic [COLOR_W+3:0] wide;
    wide = {c, {COLOR_W{1'b0}}};
    return wide[COLOR_W+3 -: COLOR_W];
  endfunction

  function automatic logic [RGB_W-1:0] reset_entry(input int i);
    rgb_t d;
    d = default_entry(i);
    return {scale_chan(d.r), scale_chan(d.g), scale_chan(d.b)};
  endfunction

  logic [RGB_W-1:0] mem [NUM_PAL][DEPTH];
  logic             invert_active;
  logic             rd_pal_ok, wr_pal_ok;
  logic [RGB_W-1:0] rd_entry;
  logic [COLOR_W-1:0] r_nxt, g_nxt, b_nxt;
  logic             t_nxt;

  palette_flash_ctrl #(.FLASH_FRAMES(FLASH_FRAMES)) u_flash (
    .Clk          (Clk),
    .Reset        (Reset),
    .flash_en     (flash_en),
    .vsync_pulse  (vsync_pulse),
    .invert_active(invert_active)
  );

  assign rd_pal_ok = 32'(pal_sel) < NUM_PAL;
  assign wr_pal_ok = 32'(wr_pal) < NUM_PAL;
  assign rd_entry  = mem[pal_sel][index];

  // Palette storage: reset reloads defaults and swallows any write.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int p = 0; p < NUM_PAL; p++)
        for (int i = 0; i < DEPTH; i++)
          mem[p][i] <= reset_entry(i);
    end else if (wr_en && wr_pal_ok) begin
      mem[wr_pal][wr_idx] <= wr_rgb;
    end
  end

  // Colour select: keyed/invalid-palette pixels are transparent black,
  // flash inverts only opaque pixels.
  always_comb begin
    r_nxt = '0;
    g_nxt = '0;
    b_nxt = '0;
    t_nxt = 1'b0;
    if (pix_valid) begin
      if (!rd_pal_ok || index == IDX_W'(TRANSP_IDX)) begin
        t_nxt = 1'b1;
      end else begin
        r_nxt = rd_entry[3*COLOR_W-1 -: COLOR_W];
        g_nxt = rd_entry[2*COLOR_W-1 -: COLOR_W];
        b_nxt = rd_entry[COLOR_W-1 -: COLOR_W];
        if (invert_active) begin
          r_nxt = ~r_nxt;
          g_nxt = ~g_nxt;
          b_nxt = ~b_nxt;
        end
      end
    end
  end

  // Output register stage.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      red         <= '0;
      green       <= '0;
      blue        <= '0;
      transparent <= 1'b0;
      out_valid   <= 1'b0;
    end else begin
      red         <= r_nxt;
      green       <= g_nxt;
      blue        <= b_nxt;
      transparent <= t_nxt;
      out_valid   <= pix_valid;
    end
  end

endmodule

// File: doc/sprite_palette_bank.md
Name: sprite_palette_bank

Overview:
Runtime-writable, multi-palette colour lookup for sprite rendering; successor to the fixed per-sprite 16-entry ROM palettes. Converts a sprite pixel index plus palette select (e.g. player 1 / player 2 colour scheme) into registered RGB with a transparency flag. Adds a frame-synchronous flash (colour-invert) mode for hit/power-up effects. Sits between the sprite ROM address stage and the VGA colour mux.

Parameters:
IDX_W, 4, pixel index width; palette depth = 2**IDX_W
COLOR_W, 4, bits per colour channel
NUM_PAL, 2, number of independent palettes
TRANSP_IDX, 1, index treated as transparent (magenta key)
FLASH_FRAMES, 8, frames per flash half-period (>=1)

Ports:
Clk  in  1  system clock
Reset  in  1  synchronous, active-high reset
pix_valid  in  1  index/pal_sel valid this cycle
pal_sel  in  PS_W=max(1,$clog2(NUM_PAL))  palette select
index  in  IDX_W  sprite pixel index
vsync_pulse  in  1  one-cycle frame-start strobe
flash_en  in  1  level: enable flash effect
wr_en  in  1  palette entry write strobe
wr_pal  in  PS_W  palette to write
wr_idx  in  IDX_W  entry to write
wr_rgb  in  3*COLOR_W  {r,g,b} value to write
red, green, blue  out  COLOR_W each  registered colour
transparent  out  1  registered: pixel is transparent
out_valid  out  1  registered copy of pix_valid

Behaviour:
- Reset (synchronous, active-high): all outputs 0; every palette entry 0..15 loaded from package DEFAULT_PALETTE (entries >=16 to 0); flash FSM to IDLE, frame counter 0. Reset mid-stream overrides all inputs that cycle, including wr_en.
- Storage: NUM_PAL x 2**IDX_W register array of 3*COLOR_W bits.
- Read: latency 1 cycle. Cycle N inputs -> cycle N+1 outputs. out_valid follows pix_valid. When pix_valid=0: rgb=0, transparent=0.
- Transparency: index==TRANSP_IDX -> transparent=1, rgb=0; flash never applies.
- Invalid palette (pal_sel>=NUM_PAL): transparent=1, rgb=0. Writes with wr_pal>=NUM_PAL ignored.
- Write: wr_en stores wr_rgb at [wr_pal][wr_idx] at the clock edge; visible to reads from cycle N+1. Read of the same entry in write cycle N returns the old value.
- Flash FSM states IDLE, FLASH_ON, FLASH_OFF; 
  IDLE: flash_en=1 -> FLASH_ON, counter 0.
  FLASH_ON/OFF: each vsync_pulse increments counter; when counter reaches FLASH_FRAMES-1 on a vsync_pulse, counter->0 and state toggles ON<->OFF.
  flash_en=0 in any state -> IDLE next cycle, counter 0 (vsync same cycle ignored).
- In FLASH_ON, non-transparent valid pixels output each channel as (2**COLOR_W-1) - c. FLASH_OFF/IDLE output true colour.
- Counter width $clog2(FLASH_FRAMES)+1; never wraps past FLASH_FRAMES-1.

Decomposition:
- Package sprite_palette_pkg: DEFAULT_PALETTE (16 x 12-bit {r,g,b}, the standard snake colour set: 2C7, F0F, B5E, 975, B99, F69, E33, 1E6, DCC, 9DB, 3D7, 2B6, 5D9, 7A8, 1C6, E9A), flash_state_t enum, rgb_t struct.
- One sub-module: palette_flash_ctrl (FSM + frame counter, outputs invert_active).

Test Plan:
- Reset, then pix_valid=1, pal_sel=0, index=0 -> next cycle rgb={2,C,7}, transparent=0, out_valid=1.
- index=1 (TRANSP_IDX) -> rgb=0, transparent=1; pix_valid=0 -> all outputs 0 next cycle.
- wr_en, wr_pal=1, wr_idx=5, wr_rgb=ABC with same-cycle read pal 1 idx 5 -> old F69; following-cycle read -> ABC; pal 0 idx 5 unchanged F69.
- flash_en=1, FLASH_FRAMES=2: index 0 outputs {D,3,8} during frames 0-1, {2,C,7} frames 2-3; index 1 stays transparent throughout.
- Drop flash_en mid FLASH_ON with simultaneous vsync_pulse -> IDLE next cycle, true colours, counter 0.
- Write to pal 1 then assert Reset mid-stream with wr_en=1 -> all entries back to DEFAULT_PALETTE, outputs 0, write lost.
